// File: rtl/dec_pkg.sv
// Shared definitions for the decoder-tree sum-of-minterms pipeline.
// Used by both the RTL and the testbench.
package dec_pkg;

  // Reset value of the minterm mask: minterms {4,5,11,12,13,14,15}.
  localparam logic [15:0] DEC_MASK_DEFAULT = 16'hF830;

  // Number of minterms for an n-input decoder.
  function automatic int MINTERMS(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/dec_2x4_en.sv
// Combinational 2-to-4 decoder with active-high enable and active-high
// outputs. With en low every output is low.
module dec_2x4_en (
  input  logic       en,
  input  logic [1:0] a,
  output logic [3:0] y
);

  // One-hot decode of a, gated by en.
  always_comb begin
    y = 4'b0000;
    if (en) y[a] = 1'b1;
  end

endmodule

// File: rtl/dec_tree_som_pipe.sv
// Two-stage decoder tree with a sum-of-minterms output.
//   Stage 1: N_IN/2 one-hot 4-bit predecode groups plus the enable.
//   Stage 2: full one-hot minterm vector (AND of groups) and
//            out_f = |(out_minterm & mask).
// Optional build macro DEC_MASK_WRITE_EN: when defined the mask is a
// register written through mask_we/mask_wdata; when undefined the mask
// is the constant MASK_INIT and the write port is ignored.
//
// Handshake: a transfer on either side happens only in a cycle where
// valid and ready are both high. Each stage loads when it is empty or
// when its downstream consumer takes its contents this cycle, so no
// transaction is dropped or duplicated and stalled outputs hold steady.
module dec_tree_som_pipe
  import dec_pkg::*;
#(
  parameter int                          N_IN      = 4,
  parameter logic [MINTERMS(N_IN)-1:0]   MASK_INIT = DEC_MASK_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_IN-1:0]             in_data,
  input  logic                        in_en,
  input  logic                        mask_we,
  input  logic [MINTERMS(N_IN)-1:0]   mask_wdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_f,
  output logic [MINTERMS(N_IN)-1:0]   out_minterm
);

  localparam int M = MINTERMS(N_IN);
  localparam int G = N_IN / 2;

  // Pipeline state
  logic             s1_valid_q, s1_valid_d;
  logic             s1_en_q, s1_en_d;
  logic [4*G-1:0]   s1_grp_q, s1_grp_d;
  logic             out_valid_q, out_valid_d;
  logic             out_f_q, out_f_d;
  logic [M-1:0]     out_minterm_q, out_minterm_d;

  // Combinational helpers
  logic             s1_load;
  logic             s2_load;
  logic [4*G-1:0]   grp_dec;
  logic [M-1:0]     minterm_comb;
  logic [M-1:0]     mask_cur;

  // Predecode: one 2-to-4 decoder per 2-bit slice of the select word.
  for (genvar g = 0; g < G; g++) begin : g_predec
    dec_2x4_en u_dec (
      .en (in_en),
      .a  (in_data[2*g+1:2*g]),
      .y  (grp_dec[4*g+3:4*g])
    );
  end

`ifdef DEC_MASK_WRITE_EN
  logic [M-1:0] mask_q, mask_d;

  // Mask register: a write becomes visible to stage-2 loads one cycle later.
  always_comb begin
    mask_d = mask_q;
    if (mask_we) mask_d = mask_wdata;
  end

  // Mask flop, restored to MASK_INIT on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_q <= MASK_INIT;
    else        mask_q <= mask_d;
  end

  assign mask_cur = mask_q;
`else
  // Fixed mask; the write port has no effect in this build.
  logic unused_mask_in;
  assign unused_mask_in = ^{mask_we, mask_wdata};
  assign mask_cur       = MASK_INIT;
`endif

  // Minterm k is the AND of, for each group g, the group bit selected by
  // slice g of k. The stored enable also gates the result.
  always_comb begin
    logic bit_and;
    minterm_comb = '0;
    for (int k = 0; k < M; k++) begin
      bit_and = s1_en_q;
      for (int g = 0; g < G; g++) begin
        bit_and = bit_and & s1_grp_q[4*g + ((k >> (2*g)) & 3)];
      end
      minterm_comb[k] = bit_and;
    end
  end

  // Stage load conditions: load when empty or when downstream drains.
  assign s2_load  = ~out_valid_q | out_ready;
  assign s1_load  = ~s1_valid_q | s2_load;
  assign in_ready = s1_load;

  // Next-state for both stages; registers hold unless their stage loads.
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_en_d       = s1_en_q;
    s1_grp_d      = s1_grp_q;
    out_valid_d   = out_valid_q;
    out_f_d       = out_f_q;
    out_minterm_d = out_minterm_q;

    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_en_d  = in_en;
        s1_grp_d = grp_dec;
      end
    end

    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_minterm_d = minterm_comb;
        out_f_d       = |(minterm_comb & mask_cur);
      end
    end
  end

  // Pipeline flops; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_en_q       <= 1'b0;
      s1_grp_q      <= '0;
      out_valid_q   <= 1'b0;
      out_f_q       <= 1'b0;
      out_minterm_q <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_en_q       <= s1_en_d;
      s1_grp_q      <= s1_grp_d;
      out_valid_q   <= out_valid_d;
      out_f_q       <= out_f_d;
      out_minterm_q <= out_minterm_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_f       = out_f_q;
  assign out_minterm = out_minterm_q;

endmodule

// File: tb/tb_dec_tree_som_pipe.sv
// Directed testbench for dec_tree_som_pipe (N_IN=4, default mask).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
module tb_dec_tree_som_pipe;
  import dec_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        in_en;
  logic        mask_we;
  logic [15:0] mask_wdata;
  logic        out_valid;
  logic        out_ready;
  logic        out_f;
  logic [15:0] out_minterm;

  int checks;
  int errors;

  dec_tree_som_pipe #(
    .N_IN      (4),
    .MASK_INIT (DEC_MASK_DEFAULT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_en       (in_en),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_f       (out_f),
    .out_minterm (out_minterm)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'd0; in_en = 1'b0;
    mask_we = 1'b0; mask_wdata = 16'h0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_f !== 1'b0 || out_minterm !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b f=%b m=%h want v=0 f=0 m=0000",
               out_valid, out_f, out_minterm);
    end
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
    next_cycle();
  endtask

  // All 16 selects, enabled, no backpressure; result two cycles later.
  task automatic test_sweep;
    logic [15:0] exp_m;
    logic        exp_f;
    int          v;
    out_ready = 1'b1;
    for (int n = 0; n < 18; n++) begin
      in_valid = (n < 16);
      in_data  = 4'(n);
      in_en    = 1'b1;
      @(negedge clk);
      if (n < 16) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL sweep_in_ready cycle %0d got %b want 1", n, in_ready);
        end
      end
      if (n >= 2) begin
        v     = n - 2;
        exp_m = 16'h0001 << v;
        exp_f = (v == 4 || v == 5 || v >= 11);
        checks++;
        if (out_valid !== 1'b1 || out_minterm !== exp_m || out_f !== exp_f) begin
          errors++;
          $display("FAIL sweep item %0d got v=%b f=%b m=%h want v=1 f=%b m=%h",
                   v, out_valid, out_f, out_minterm, exp_f, exp_m);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL sweep_latency cycle %0d got out_valid=%b want 0", n, out_valid);
        end
      end
      next_cycle();
    end
    in_valid = 1'b0;
  endtask

  // in_en=0 still flows through and produces all-zero outputs.
  task automatic test_disabled;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      in_valid = (n == 0);
      in_data  = 4'd5;
      in_en    = 1'b0;
      @(negedge clk);
      checks++;
      if (n == 2) begin
        if (out_valid !== 1'b1 || out_f !== 1'b0 || out_minterm !== 16'h0000) begin
          errors++;
          $display("FAIL disabled got v=%b f=%b m=%h want v=1 f=0 m=0000",
                   out_valid, out_f, out_minterm);
        end
      end else begin
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL disabled_extra cycle %0d got out_valid=%b want 0", n, out_valid);
        end
      end
      next_cycle();
    end
    in_valid = 1'b0;
    in_en    = 1'b1;
  endtask

  // Stream 0..7 with out_ready cycling 1,0,0,1.
  task automatic test_back_to_back;
    logic [3:0]  exp_q[$];
    bit   [3:0]  pat = 4'b1001;
    int          next_item;
    int          emitted;
    int          inflight;
    int          c;
    bit          prev_stall;
    logic [15:0] prev_m;
    logic        prev_f;
    logic [3:0]  exp_v;
    logic        exp_rdy;
    logic        acc;
    logic        emit;
    next_item = 0; emitted = 0; inflight = 0; c = 0; prev_stall = 0;
    prev_m = '0; prev_f = 1'b0;
    in_en = 1'b1;
    while (emitted < 8 && c < 100) begin
      in_valid  = (next_item < 8);
      in_data   = 4'(next_item);
      out_ready = pat[c % 4];
      @(negedge clk);
      exp_rdy = !(inflight == 2 && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL bp_in_ready cycle %0d got %b want %b", c, in_ready, exp_rdy);
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_minterm !== prev_m || out_f !== prev_f) begin
          errors++;
          $display("FAIL bp_hold cycle %0d got v=%b f=%b m=%h want v=1 f=%b m=%h",
                   c, out_valid, out_f, out_minterm, prev_f, prev_m);
        end
      end
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      if (emit) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra cycle %0d got m=%h want no output", c, out_minterm);
        end else begin
          exp_v = exp_q.pop_front();
          if (out_minterm !== (16'h0001 << exp_v) ||
              out_f !== (exp_v == 4 || exp_v == 5 || exp_v >= 11)) begin
            errors++;
            $display("FAIL bp_order item %0d got f=%b m=%h want m=%h",
                     exp_v, out_f, out_minterm, 16'h0001 << exp_v);
          end
        end
        emitted++;
      end
      if (acc) begin
        exp_q.push_back(4'(next_item));
        next_item++;
      end
      inflight   = inflight + int'(acc) - int'(emit);
      prev_stall = out_valid && !out_ready;
      prev_m     = out_minterm;
      prev_f     = out_f;
      c++;
      next_cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (emitted != 8 || exp_q.size() != 0 || next_item != 8) begin
      errors++;
      $display("FAIL bp_count got emitted=%0d accepted=%0d want 8 8", emitted, next_item);
    end
    next_cycle();
    next_cycle();
  endtask

`ifdef DEC_MASK_WRITE_EN
  // Mask write coinciding with a stage-2 load uses the old mask.
  task automatic test_mask_collision;
    out_ready = 1'b1; in_en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      in_valid   = (n == 0 || n == 2 || n == 3);
      in_data    = (n == 3) ? 4'd0 : 4'd4;
      mask_we    = (n == 1);
      mask_wdata = 16'h0001;
      @(negedge clk);
      if (n == 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_f !== 1'b1 || out_minterm !== 16'h0010) begin
          errors++;
          $display("FAIL mask_old got v=%b f=%b m=%h want v=1 f=1 m=0010",
                   out_valid, out_f, out_minterm);
        end
      end
      if (n == 4) begin
        checks++;
        if (out_valid !== 1'b1 || out_f !== 1'b0 || out_minterm !== 16'h0010) begin
          errors++;
          $display("FAIL mask_new4 got v=%b f=%b m=%h want v=1 f=0 m=0010",
                   out_valid, out_f, out_minterm);
        end
      end
      if (n == 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_f !== 1'b1 || out_minterm !== 16'h0001) begin
          errors++;
          $display("FAIL mask_new0 got v=%b f=%b m=%h want v=1 f=1 m=0001",
                   out_valid, out_f, out_minterm);
        end
      end
      next_cycle();
    end
    in_valid = 1'b0;
    mask_we  = 1'b0;
  endtask
`else
  // Without the write feature the mask stays at its reset constant.
  task automatic test_mask_fixed;
    out_ready = 1'b1; in_en = 1'b1;
    for (int n = 0; n < 5; n++) begin
      mask_we    = (n == 0);
      mask_wdata = 16'h0000;
      in_valid   = (n == 1);
      in_data    = 4'd12;
      @(negedge clk);
      if (n == 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_f !== 1'b1 || out_minterm !== 16'h1000) begin
          errors++;
          $display("FAIL mask_fixed got v=%b f=%b m=%h want v=1 f=1 m=1000",
                   out_valid, out_f, out_minterm);
        end
      end
      next_cycle();
    end
    in_valid = 1'b0;
    mask_we  = 1'b0;
  endtask
`endif

  // Reset with two transactions in flight discards both.
  task automatic test_reset_midflight;
    out_ready = 1'b0; in_en = 1'b1;
    in_valid = 1'b1; in_data = 4'd1;
    next_cycle();
    in_data = 4'd2;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midflight_full got out_valid=%b in_ready=%b want 1 0",
               out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_minterm !== 16'h0) begin
      errors++;
      $display("FAIL midflight_async got v=%b m=%h want v=0 m=0000", out_valid, out_minterm);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    next_cycle();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midflight_leak cycle %0d got out_valid=%b want 0", n, out_valid);
      end
      next_cycle();
    end
    for (int n = 0; n < 4; n++) begin
      in_valid = (n == 0);
      in_data  = 4'd11;
      @(negedge clk);
      if (n == 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_f !== 1'b1 || out_minterm !== 16'h0800) begin
          errors++;
          $display("FAIL midflight_mask got v=%b f=%b m=%h want v=1 f=1 m=0800",
                   out_valid, out_f, out_minterm);
        end
      end
      next_cycle();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sweep();
    test_disabled();
    test_back_to_back();
`ifdef DEC_MASK_WRITE_EN
    test_mask_collision();
`else
    test_mask_fixed();
`endif
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #50000;
    $display("FAIL timeout got no finish want finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
